// File: rtl/md_pkg.sv
// Shared multiply/divide definitions.
// Used by md_unit, the EX-stage controller and the hazard/stall unit.
// Contents:
//   md_op_e     - 3-bit operation code driven on md_op (code 7 is reserved and acts as a no-op)
//   md_state_e  - md_unit sequencer states
//   MULT_CYCLES - busy cycles for MULT/MULTU
//   DIV_CYCLES  - busy cycles for DIV/DIVU
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDiv  = 2'd2
  } md_state_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // True for the ops that hold busy for several cycles.
  function automatic logic md_is_multi_cycle(logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit holding the HI/LO register pair.
// The operands are captured when the op is accepted. The product, quotient and remainder are
// computed combinationally from those captured operands and are written into HI/LO on the
// final edge of the busy window.
// Ports:
//   clk   - clock; all state changes on the rising edge
//   reset - synchronous, active-high
//   start - op valid this cycle (EX stage)
//   md_op - operation code (md_pkg::md_op_e)
//   a, b  - forwarded rs/rt operands
//   busy  - multi-cycle op in flight (registered)
//   hi    - HI register
//   lo    - LO register
module md_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   r_state;
  logic [3:0]  r_cnt;
  logic        r_busy;
  logic        r_signed;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Product: sign- or zero-extend both operands to 64 bits; the low 64 bits of the product
  // are then correct for both the signed and the unsigned case.
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;

  assign w_ext_a = r_signed ? {{32{r_a[31]}}, r_a} : {32'd0, r_a};
  assign w_ext_b = r_signed ? {{32{r_b[31]}}, r_b} : {32'd0, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Division. The divisor is forced to 1 when it is zero; that result is never written.
  // INT_MIN / -1 has no representable quotient, so it is handled separately and never
  // reaches the divider: the quotient wraps to INT_MIN and the remainder is 0.
  logic               w_div_zero;
  logic               w_ovf;
  logic [31:0]        w_b_safe;
  logic signed [31:0] w_sa;
  logic signed [31:0] w_sb;
  logic signed [31:0] w_q_s;
  logic signed [31:0] w_r_s;
  logic [31:0]        w_q_u;
  logic [31:0]        w_r_u;
  logic [31:0]        w_quot;
  logic [31:0]        w_rem;

  assign w_div_zero = (r_b == 32'd0);
  assign w_ovf      = r_signed && (r_a == 32'h8000_0000) && (r_b == 32'hFFFF_FFFF);
  assign w_b_safe   = (w_div_zero || w_ovf) ? 32'd1 : r_b;
  assign w_sa       = r_a;
  assign w_sb       = w_b_safe;
  // Signed / and % truncate toward zero, so the remainder takes the sign of the dividend.
  assign w_q_s      = w_sa / w_sb;
  assign w_r_s      = w_sa % w_sb;
  assign w_q_u      = r_a / w_b_safe;
  assign w_r_u      = r_a % w_b_safe;
  assign w_quot     = w_ovf ? 32'h8000_0000 : (r_signed ? w_q_s : w_q_u);
  assign w_rem      = w_ovf ? 32'd0 : (r_signed ? w_r_s : w_r_u);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_signed <= 1'b0;
      r_a      <= 32'd0;
      r_b      <= 32'd0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            case (md_op)
              MD_MULT, MD_MULTU: begin
                r_state  <= StMul;
                r_cnt    <= MULT_CYCLES;
                r_busy   <= 1'b1;
                r_signed <= (md_op == MD_MULT);
                r_a      <= a;
                r_b      <= b;
              end
              MD_DIV, MD_DIVU: begin
                r_state  <= StDiv;
                r_cnt    <= DIV_CYCLES;
                r_busy   <= 1'b1;
                r_signed <= (md_op == MD_DIV);
                r_a      <= a;
                r_b      <= b;
              end
              MD_MTHI: r_hi <= a;
              MD_MTLO: r_lo <= a;
              default: ;  // MD_NONE and reserved code 7
            endcase
          end
        end
        StMul: begin
          if (r_cnt == 4'd1) begin
            {r_hi, r_lo} <= w_prod;
            r_state      <= StIdle;
            r_busy       <= 1'b0;
            r_cnt        <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        StDiv: begin
          if (r_cnt == 4'd1) begin
            // Divide by zero still takes the full busy window but leaves HI/LO alone.
            if (!w_div_zero) begin
              r_lo <= w_quot;
              r_hi <= w_rem;
            end
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Directed testbench for md_unit. Inputs are driven and outputs sampled on the falling edge.
module tb_md_unit;
  import md_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int total;
  int bad;

  md_unit u_dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one start pulse across a rising edge (E0), then scramble the operands.
  // Returns at the falling edge of the first cycle after E0.
  task automatic do_start(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1;
    md_op = op;
    a     = av;
    b     = bv;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    a     = 32'hA5A5_A5A5;
    b     = 32'h5A5A_5A5A;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    md_op = 3'd0;
    a     = 32'd0;
    b     = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++;
    if (hi !== 32'd0) begin bad++; $display("FAIL reset_hi: got %h want 0", hi); end
    total++;
    if (lo !== 32'd0) begin bad++; $display("FAIL reset_lo: got %h want 0", lo); end
  endtask

  // MULT -3 * 7; HI/LO must hold at 0 until the final edge.
  task automatic test_mult();
    int n;
    logic held;
    do_start(MD_MULT, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    held = 1'b1;
    while (busy === 1'b1 && n < 30) begin
      if (hi !== 32'd0 || lo !== 32'd0) held = 1'b0;
      n++;
      @(negedge clk);
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    total++;
    if (held !== 1'b1) begin bad++; $display("FAIL mult_hold: hi/lo changed during busy, got %b want 1", held); end
    total++;
    if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
    total++;
    if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_multu();
    int n;
    do_start(MD_MULTU, 32'hFFFF_FFFD, 32'd7);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (n != 5) begin bad++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    total++;
    if (hi !== 32'h0000_0006) begin bad++; $display("FAIL multu_hi: got %h want 00000006", hi); end
    total++;
    if (lo !== 32'hFFFF_FFEB) begin bad++; $display("FAIL multu_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_div();
    int n;
    do_start(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin bad++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    total++;
    if (lo !== 32'hFFFF_FFFD) begin bad++; $display("FAIL div_lo: got %h want fffffffd", lo); end
    total++;
    if (hi !== 32'hFFFF_FFFF) begin bad++; $display("FAIL div_hi: got %h want ffffffff", hi); end
    do_start(MD_DIVU, 32'd7, 32'd2);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin bad++; $display("FAIL divu_busy_cycles: got %0d want 10", n); end
    total++;
    if (lo !== 32'd3) begin bad++; $display("FAIL divu_lo: got %h want 00000003", lo); end
    total++;
    if (hi !== 32'd1) begin bad++; $display("FAIL divu_hi: got %h want 00000001", hi); end
  endtask

  // MTHI, then DIVU by zero: HI keeps the MTHI value, LO keeps 3 from the DIVU before.
  task automatic test_div_zero();
    int n;
    do_start(MD_MTHI, 32'h1234_5678, 32'd0);
    total++;
    if (hi !== 32'h1234_5678) begin bad++; $display("FAIL mthi_hi: got %h want 12345678", hi); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mthi_busy: got %b want 0", busy); end
    total++;
    if (lo !== 32'd3) begin bad++; $display("FAIL mthi_lo_untouched: got %h want 00000003", lo); end
    do_start(MD_DIVU, 32'd5, 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin bad++; $display("FAIL divzero_busy_cycles: got %0d want 10", n); end
    repeat (2) @(negedge clk);
    total++;
    if (hi !== 32'h1234_5678) begin bad++; $display("FAIL divzero_hi: got %h want 12345678", hi); end
    total++;
    if (lo !== 32'd3) begin bad++; $display("FAIL divzero_lo: got %h want 00000003", lo); end
  endtask

  // MD_NONE and reserved code 7 must do nothing.
  task automatic test_noop();
    do_start(3'd7, 32'hDEAD_BEEF, 32'd3);
    total++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'd3) begin
      bad++;
      $display("FAIL reserved_op: got busy=%b hi=%h lo=%h want busy=0 hi=12345678 lo=00000003",
               busy, hi, lo);
    end
    do_start(MD_NONE, 32'hDEAD_BEEF, 32'd3);
    total++;
    if (busy !== 1'b0 || hi !== 32'h1234_5678 || lo !== 32'd3) begin
      bad++;
      $display("FAIL none_op: got busy=%b hi=%h lo=%h want busy=0 hi=12345678 lo=00000003",
               busy, hi, lo);
    end
  endtask

  // Reset asserted during the 4th busy cycle of a DIV discards it.
  task automatic test_reset_midway();
    do_start(MD_DIV, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL midreset_busy_before: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL midreset_after: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
    end
    repeat (12) @(negedge clk);
    total++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      bad++;
      $display("FAIL midreset_late: got busy=%b hi=%h lo=%h want busy=0 hi=0 lo=0", busy, hi, lo);
    end
  endtask

  // MTLO issued while a MULT is busy is ignored.
  task automatic test_mtlo_during_busy();
    int n;
    do_start(MD_MULT, 32'd6, 32'd7);
    start = 1'b1;
    md_op = MD_MTLO;
    a     = 32'd9;
    n = 0;
    while (busy === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd0;
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL mtlo_busy_cycles: got %0d want 5", n); end
    total++;
    if (lo !== 32'd42) begin bad++; $display("FAIL mtlo_ignored_lo: got %h want 0000002a", lo); end
    total++;
    if (hi !== 32'd0) begin bad++; $display("FAIL mtlo_ignored_hi: got %h want 00000000", hi); end
  endtask

  // A new op is accepted in the first idle cycle after completion.
  task automatic test_back_to_back();
    int n;
    do_start(MD_MULTU, 32'd3, 32'd5);
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (lo !== 32'd15) begin bad++; $display("FAIL b2b_first_lo: got %h want 0000000f", lo); end
    // Still at the first busy=0 falling edge: start immediately.
    start = 1'b1;
    md_op = MD_DIVU;
    a     = 32'd100;
    b     = 32'd7;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL b2b_accept: got busy=%b want 1", busy); end
    n = 0;
    while (busy === 1'b1 && n < 30) begin n++; @(negedge clk); end
    total++;
    if (n != 10) begin bad++; $display("FAIL b2b_busy_cycles: got %0d want 10", n); end
    total++;
    if (lo !== 32'd14 || hi !== 32'd2) begin
      bad++;
      $display("FAIL b2b_divu: got hi=%h lo=%h want hi=00000002 lo=0000000e", hi, lo);
    end
    // MTHI right after completion sees the written LO untouched.
    start = 1'b1;
    md_op = MD_MTHI;
    a     = 32'hCAFE_0001;
    @(negedge clk);
    start = 1'b0;
    md_op = 3'd0;
    total++;
    if (hi !== 32'hCAFE_0001 || lo !== 32'd14) begin
      bad++;
      $display("FAIL b2b_mthi: got hi=%h lo=%h want hi=cafe0001 lo=0000000e", hi, lo);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_noop();
    test_reset_midway();
    test_mtlo_during_busy();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
